// File: rtl/config_pkg.sv
// Minimal core-configuration package for lpad_elp_ctrl.
// It provides only the configuration type and default used by this block,
// along with the two-state ELP type. Swap in the full project package when
// integrating into a complete core.
package config_pkg;

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

  // Expected-landing-pad state.
  typedef enum logic {
    NO_LP_EXPECTED = 1'b0,
    LP_EXPECTED    = 1'b1
  } elp_t;

endpackage

// File: rtl/lpad_elp_ctrl.sv
// lpad_elp_ctrl: owns the architectural ELP (expected landing pad) state and
// the copies of it that traps, xRETs and debug entry save and restore.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   elp_next_i           ELP after the landing-pad check of this cycle's commits
//   commit_ack_i         per-port commit acknowledge
//   trap_valid_i         trap taken this cycle
//   trap_to_s_i          trap targets S-mode (0 = M-mode)
//   mret_i, sret_i       xRET committed this cycle
//   lpe_ret_i            landing pads enabled in the mode being returned to
//   debug_req_i, dret_i  debug-mode entry / exit
//   csr_we_mpelp_i,
//   csr_we_spelp_i,
//   csr_wdata_i          software writes to mstatus.MPELP / sstatus.SPELP
//   elp_o                current ELP state (registered)
//   mpelp_o, spelp_o     saved ELP fields (registered)
//
// All outputs come straight from flops; there is no input-to-output path.
module lpad_elp_ctrl #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  config_pkg::elp_t                 elp_next_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0] commit_ack_i,
  input  logic                             trap_valid_i,
  input  logic                             trap_to_s_i,
  input  logic                             mret_i,
  input  logic                             sret_i,
  input  logic                             lpe_ret_i,
  input  logic                             debug_req_i,
  input  logic                             dret_i,
  input  logic                             csr_we_mpelp_i,
  input  logic                             csr_we_spelp_i,
  input  logic                             csr_wdata_i,
  output config_pkg::elp_t                 elp_o,
  output logic                             mpelp_o,
  output logic                             spelp_o
);

  import config_pkg::*;

  elp_t elp_q, elp_d;
  logic mpelp_q, mpelp_d;
  logic spelp_q, spelp_d;
  logic dpelp_q, dpelp_d;

  always_comb begin
    elp_d   = elp_q;
    dpelp_d = dpelp_q;
    // CSR writes land first; any event below that owns the same field
    // overwrites them, so trap/xRET always win over software.
    mpelp_d = csr_we_mpelp_i ? csr_wdata_i : mpelp_q;
    spelp_d = csr_we_spelp_i ? csr_wdata_i : spelp_q;

    if (debug_req_i) begin
      dpelp_d = elp_q;
      elp_d   = NO_LP_EXPECTED;
    end else if (trap_valid_i) begin
      if (trap_to_s_i) spelp_d = elp_q;
      else             mpelp_d = elp_q;
      elp_d = NO_LP_EXPECTED;
    end else if (dret_i) begin
      elp_d   = elp_t'(dpelp_q);
      dpelp_d = 1'b0;
    end else if (mret_i) begin
      // mret has precedence when both xRETs are flagged together.
      elp_d   = lpe_ret_i ? elp_t'(mpelp_q) : NO_LP_EXPECTED;
      mpelp_d = 1'b0;
    end else if (sret_i) begin
      elp_d   = lpe_ret_i ? elp_t'(spelp_q) : NO_LP_EXPECTED;
      spelp_d = 1'b0;
    end else if (|commit_ack_i) begin
      elp_d = elp_next_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elp_q   <= NO_LP_EXPECTED;
      mpelp_q <= 1'b0;
      spelp_q <= 1'b0;
      dpelp_q <= 1'b0;
    end else begin
      elp_q   <= elp_d;
      mpelp_q <= mpelp_d;
      spelp_q <= spelp_d;
      dpelp_q <= dpelp_d;
    end
  end

  assign elp_o   = elp_q;
  assign mpelp_o = mpelp_q;
  assign spelp_o = spelp_q;

endmodule

// File: tb/tb_lpad_elp_ctrl.sv
// Self-checking bench for lpad_elp_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the ELP save/restore rules.
module tb_lpad_elp_ctrl;

  import config_pkg::*;

  localparam int NC = config_pkg::cva6_cfg_empty.NrCommitPorts;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  elp_t          elp_next_i = NO_LP_EXPECTED;
  logic [NC-1:0] commit_ack_i = '0;
  logic          trap_valid_i = 1'b0, trap_to_s_i = 1'b0;
  logic          mret_i = 1'b0, sret_i = 1'b0, lpe_ret_i = 1'b0;
  logic          debug_req_i = 1'b0, dret_i = 1'b0;
  logic          csr_we_mpelp_i = 1'b0, csr_we_spelp_i = 1'b0, csr_wdata_i = 1'b0;
  elp_t          elp_o;
  logic          mpelp_o, spelp_o;

  int checks = 0;
  int errors = 0;

  lpad_elp_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .elp_next_i     (elp_next_i),
    .commit_ack_i   (commit_ack_i),
    .trap_valid_i   (trap_valid_i),
    .trap_to_s_i    (trap_to_s_i),
    .mret_i         (mret_i),
    .sret_i         (sret_i),
    .lpe_ret_i      (lpe_ret_i),
    .debug_req_i    (debug_req_i),
    .dret_i         (dret_i),
    .csr_we_mpelp_i (csr_we_mpelp_i),
    .csr_we_spelp_i (csr_we_spelp_i),
    .csr_wdata_i    (csr_wdata_i),
    .elp_o          (elp_o),
    .mpelp_o        (mpelp_o),
    .spelp_o        (spelp_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: pick the single winning event from a priority list,
  // apply its effect, and let CSR writes stick only to fields nobody else
  // claimed this cycle.
  logic m_elp = 1'b0, m_mp = 1'b0, m_sp = 1'b0, m_dp = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_elp <= 1'b0; m_mp <= 1'b0; m_sp <= 1'b0; m_dp <= 1'b0;
    end else begin
      automatic logic ev [6];
      automatic int   win = 6;
      automatic logic n_elp = m_elp, n_mp = m_mp, n_sp = m_sp, n_dp = m_dp;
      automatic bit   mp_claimed = 0, sp_claimed = 0;
      ev[0] = debug_req_i; ev[1] = trap_valid_i; ev[2] = dret_i;
      ev[3] = mret_i;      ev[4] = sret_i;       ev[5] = (commit_ack_i != '0);
      for (int i = 5; i >= 0; i--) if (ev[i]) win = i;
      case (win)
        0: begin n_dp = m_elp; n_elp = 1'b0; end
        1: begin
          if (trap_to_s_i) begin n_sp = m_elp; sp_claimed = 1; end
          else             begin n_mp = m_elp; mp_claimed = 1; end
          n_elp = 1'b0;
        end
        2: begin n_elp = m_dp; n_dp = 1'b0; end
        3: begin n_elp = lpe_ret_i & m_mp; n_mp = 1'b0; mp_claimed = 1; end
        4: begin n_elp = lpe_ret_i & m_sp; n_sp = 1'b0; sp_claimed = 1; end
        5: n_elp = elp_next_i;
        default: ;
      endcase
      if (csr_we_mpelp_i && !mp_claimed) n_mp = csr_wdata_i;
      if (csr_we_spelp_i && !sp_claimed) n_sp = csr_wdata_i;
      m_elp <= n_elp; m_mp <= n_mp; m_sp <= n_sp; m_dp <= n_dp;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    checks++;
    if ({elp_o, mpelp_o, spelp_o} !== {m_elp, m_mp, m_sp}) begin
      errors++;
      $display("FAIL model_cmp t=%0t actual elp/mp/sp=%b%b%b required=%b%b%b",
               $time, elp_o, mpelp_o, spelp_o, m_elp, m_mp, m_sp);
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic idle();
    elp_next_i = NO_LP_EXPECTED; commit_ack_i = '0;
    trap_valid_i = 0; trap_to_s_i = 0; mret_i = 0; sret_i = 0; lpe_ret_i = 0;
    debug_req_i = 0; dret_i = 0;
    csr_we_mpelp_i = 0; csr_we_spelp_i = 0; csr_wdata_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic set_elp1();
    commit_ack_i = 2'b01; elp_next_i = LP_EXPECTED; step();
  endtask

  initial begin
    idle();
    #2;
    check("reset_elp", elp_o, 1'b0);
    check("reset_mp", mpelp_o, 1'b0);
    check("reset_sp", spelp_o, 1'b0);
    step();
    rst_ni = 1'b1;
    step();

    // Commit loads elp_next; no commit holds regardless of elp_next.
    commit_ack_i = 2'b01; elp_next_i = LP_EXPECTED; step();
    check("commit_load", elp_o, 1'b1);
    commit_ack_i = 2'b00; elp_next_i = NO_LP_EXPECTED; step();
    check("commit_hold", elp_o, 1'b1);

    // M-trap saves, mret restores with landing pads enabled.
    trap_valid_i = 1; trap_to_s_i = 0; step();
    check("mtrap_mp", mpelp_o, 1'b1);
    check("mtrap_elp", elp_o, 1'b0);
    mret_i = 1; lpe_ret_i = 1; step();
    check("mret_elp", elp_o, 1'b1);
    check("mret_mp", mpelp_o, 1'b0);

    // S-trap saves, sret with landing pads disabled clears.
    trap_valid_i = 1; trap_to_s_i = 1; step();
    check("strap_sp", spelp_o, 1'b1);
    sret_i = 1; lpe_ret_i = 0; step();
    check("sret_elp", elp_o, 1'b0);
    check("sret_sp", spelp_o, 1'b0);

    // Trap beats commit and CSR write in the same cycle.
    set_elp1();
    trap_valid_i = 1; commit_ack_i = 2'b11; elp_next_i = LP_EXPECTED;
    csr_we_mpelp_i = 1; csr_wdata_i = 0; step();
    check("trap_prio_mp", mpelp_o, 1'b1);
    check("trap_prio_elp", elp_o, 1'b0);
    mret_i = 1; lpe_ret_i = 0; step();
    check("mret_nolpe_mp", mpelp_o, 1'b0);

    // Debug entry beats trap; dret restores.
    set_elp1();
    debug_req_i = 1; trap_valid_i = 1; step();
    check("dbg_elp", elp_o, 1'b0);
    check("dbg_mp", mpelp_o, 1'b0);
    dret_i = 1; step();
    check("dret_elp", elp_o, 1'b1);

    // CSR write takes effect when no event claims the field.
    csr_we_spelp_i = 1; csr_wdata_i = 1; step();
    check("csr_sp", spelp_o, 1'b1);
    sret_i = 1; mret_i = 1; lpe_ret_i = 1; step();
    check("both_ret_sp_kept", spelp_o, 1'b1);

    // Reset in the same cycle as a trap.
    set_elp1();
    trap_valid_i = 1; rst_ni = 1'b0; #1;
    check("rst_async_elp", elp_o, 1'b0);
    check("rst_async_mp", mpelp_o, 1'b0);
    check("rst_async_sp", spelp_o, 1'b0);
    step();
    rst_ni = 1'b1; step();
    check("rst_after_elp", elp_o, 1'b0);
    check("rst_after_mp", mpelp_o, 1'b0);

    // Randomized traffic; the per-cycle comparator does the checking.
    for (int n = 0; n < 3000; n++) begin
      debug_req_i    = ($urandom_range(0, 99) < 3);
      trap_valid_i   = ($urandom_range(0, 99) < 8);
      trap_to_s_i    = $urandom_range(0, 1);
      dret_i         = ($urandom_range(0, 99) < 6);
      mret_i         = ($urandom_range(0, 99) < 8);
      sret_i         = ($urandom_range(0, 99) < 8);
      lpe_ret_i      = ($urandom_range(0, 99) < 70);
      commit_ack_i   = NC'($urandom);
      elp_next_i     = elp_t'($urandom_range(0, 1));
      csr_we_mpelp_i = ($urandom_range(0, 99) < 10);
      csr_we_spelp_i = ($urandom_range(0, 99) < 10);
      csr_wdata_i    = $urandom_range(0, 1);
      if ($urandom_range(0, 199) == 0) rst_ni = 1'b0;
      else                             rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
    end
    idle();
    rst_ni = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
